// File: rtl/locked_core_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : locked_core_sequencer_if
// Description : Bundles the key stream, host request/response and locked-core
//               ap_ctrl_hs signals of the locked core sequencer.
//               slave  = sequencer side, master = environment side.
// Revision    : 1.0 - initial release
// ============================================================================
interface locked_core_sequencer_if #(
    parameter int KEY_WIDTH = 12287,
    parameter int WORD_W    = 32
);
    // Key provisioning stream
    logic                 key_valid;
    logic                 key_ready;
    logic [WORD_W-1:0]    key_data;
    logic                 key_reload;
    logic                 key_loaded;
    // Host request / response
    logic                 req_valid;
    logic                 req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_data;
    logic                 rsp_err;
    logic                 busy;
    // Locked core ap_ctrl_hs side
    logic                 core_start;
    logic                 core_ready;
    logic                 core_done;
    logic                 core_idle;
    logic [31:0]          core_return;
    logic [KEY_WIDTH-1:0] core_key;

    modport slave (
        input  key_valid, key_data, key_reload,
        input  req_valid, rsp_ready,
        input  core_ready, core_done, core_idle, core_return,
        output key_ready, key_loaded,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy,
        output core_start, core_key
    );

    modport master (
        output key_valid, key_data, key_reload,
        output req_valid, rsp_ready,
        output core_ready, core_done, core_idle, core_return,
        input  key_ready, key_loaded,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy,
        input  core_start, core_key
    );
endinterface
`default_nettype wire

// File: rtl/locked_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : locked_core_sequencer
// Description : Loads the locked core's working key from a 32-bit word stream,
//               then runs the core's ap_start/ap_ready/ap_done handshake for a
//               single host and returns ap_return on a valid/ready response
//               port, with a watchdog that reports an error on timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module locked_core_sequencer #(
    parameter int KEY_WIDTH   = 12287,
    parameter int WORD_W      = 32,
    parameter int TIMEOUT_CYC = 65535
) (
    input  wire logic              ap_clk,
    input  wire logic              ap_rst,
    locked_core_sequencer_if.slave bus
);

    localparam int c_NUM_WORDS = (KEY_WIDTH + WORD_W - 1) / WORD_W;
    localparam int c_WCNT_W    = (c_NUM_WORDS > 1) ? $clog2(c_NUM_WORDS) : 1;
    localparam int c_TCNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(c_NUM_WORDS - 1);
    localparam logic [c_TCNT_W-1:0] c_TCNT_LAST = c_TCNT_W'(TIMEOUT_CYC - 1);

    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_READY = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic [c_TCNT_W-1:0] r_tcnt;
    logic                r_reload_pend;
    logic                r_key_loaded;
    logic                r_core_start;
    logic                r_rsp_valid;
    logic [31:0]         r_rsp_data;
    logic                r_rsp_err;

    logic                w_key_hs;
    logic                w_key_last;
    logic                w_req_ready;
    logic                w_req_hs;
    logic                w_rsp_hs;
    logic                w_reload_any;
    logic                w_enter_load;
    logic                w_tcnt_term;
    logic                w_capture;
    logic [31:0]         w_cap_data;
    logic                w_cap_err;
    wire [KEY_WIDTH-1:0] w_core_key;

    assign w_key_hs     = (r_state == S_LOAD) && bus.key_valid;
    assign w_key_last   = w_key_hs && (r_wcnt == c_WCNT_LAST);
    // A reload request in the same cycle takes priority, so the request is not
    // acknowledged and then silently dropped.
    assign w_req_ready  = (r_state == S_READY) && bus.core_idle && !r_reload_pend && !bus.key_reload;
    assign w_req_hs     = bus.req_valid && w_req_ready;
    assign w_rsp_hs     = r_rsp_valid && bus.rsp_ready;
    assign w_reload_any = r_reload_pend || bus.key_reload;
    assign w_enter_load = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    assign w_tcnt_term  = (r_tcnt == c_TCNT_LAST);

    // State register
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) r_state <= S_LOAD;
        else        r_state <= w_state_nxt;
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOAD:  if (w_key_last) w_state_nxt = S_READY;
            S_READY: begin
                if (w_reload_any)  w_state_nxt = S_LOAD;
                else if (w_req_hs) w_state_nxt = S_START;
            end
            S_START: if (bus.core_ready) w_state_nxt = bus.core_done ? S_RESP : S_WAIT;
            S_WAIT:  if (bus.core_done || w_tcnt_term) w_state_nxt = S_RESP;
            S_RESP:  if (w_rsp_hs) w_state_nxt = w_reload_any ? S_LOAD : S_READY;
            default: w_state_nxt = S_LOAD;
        endcase
    end

    // Result capture decode; core_done on the terminal-count cycle wins
    always_comb begin
        w_capture  = 1'b0;
        w_cap_data = 32'h0;
        w_cap_err  = 1'b0;
        if (r_state == S_START && bus.core_ready && bus.core_done) begin
            w_capture  = 1'b1;
            w_cap_data = bus.core_return;
        end else if (r_state == S_WAIT && bus.core_done) begin
            w_capture  = 1'b1;
            w_cap_data = bus.core_return;
        end else if (r_state == S_WAIT && w_tcnt_term) begin
            w_capture  = 1'b1;
            w_cap_err  = 1'b1;
        end
    end

    // Registered outputs, derived from the next state so they align with it
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_core_start <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= 32'h0;
            r_rsp_err    <= 1'b0;
            r_key_loaded <= 1'b0;
        end else begin
            r_core_start <= (w_state_nxt == S_START);
            r_rsp_valid  <= (w_state_nxt == S_RESP);
            if (w_capture) begin
                r_rsp_data <= w_cap_data;
                r_rsp_err  <= w_cap_err;
            end
            if (w_enter_load)    r_key_loaded <= 1'b0;
            else if (w_key_last) r_key_loaded <= 1'b1;
        end
    end

    // Key word counter, watchdog counter and deferred reload flag
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_wcnt        <= '0;
            r_tcnt        <= '0;
            r_reload_pend <= 1'b0;
        end else begin
            if (w_enter_load)    r_wcnt <= '0;
            else if (w_key_last) r_wcnt <= '0;
            else if (w_key_hs)   r_wcnt <= r_wcnt + 1'b1;

            // Saturates at terminal count rather than wrapping
            if (w_rsp_hs)                              r_tcnt <= '0;
            else if (r_state == S_WAIT && !w_tcnt_term) r_tcnt <= r_tcnt + 1'b1;

            if (w_enter_load) r_reload_pend <= 1'b0;
            else if (bus.key_reload && (r_state == S_START || r_state == S_WAIT || r_state == S_RESP))
                r_reload_pend <= 1'b1;
        end
    end

    // One register slice per key word; the last slice drops bits past KEY_WIDTH
    for (genvar k = 0; k < c_NUM_WORDS; k++) begin : g_key_word
        localparam int c_LO = k * WORD_W;
        localparam int c_SW = ((KEY_WIDTH - c_LO) < WORD_W) ? (KEY_WIDTH - c_LO) : WORD_W;
        localparam logic [c_WCNT_W-1:0] c_IDX = c_WCNT_W'(k);
        logic [c_SW-1:0] r_word;

        // Write this slice when its word index is handshaken, clear on LOAD entry
        always_ff @(posedge ap_clk or posedge ap_rst) begin
            if (ap_rst)                             r_word <= '0;
            else if (w_enter_load)                  r_word <= '0;
            else if (w_key_hs && (r_wcnt == c_IDX)) r_word <= bus.key_data[c_SW-1:0];
        end

        assign w_core_key[c_LO +: c_SW] = r_word;
    end

    assign bus.key_ready  = (r_state == S_LOAD);
    assign bus.req_ready  = w_req_ready;
    assign bus.busy       = (r_state != S_READY);
    assign bus.key_loaded = r_key_loaded;
    assign bus.core_start = r_core_start;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign bus.core_key   = w_core_key;

endmodule
`default_nettype wire

// File: tb/tb_locked_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_locked_core_sequencer
// Description : Self-checking bench for locked_core_sequencer with a small
//               locked-core model and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_locked_core_sequencer;

    localparam int KW = 12287;
    localparam int WW = 32;
    localparam int TO = 16;

    logic ap_clk = 1'b0;
    logic ap_rst;

    always #5 ap_clk = ~ap_clk;

    locked_core_sequencer_if #(.KEY_WIDTH(KW), .WORD_W(WW)) bus ();

    locked_core_sequencer #(
        .KEY_WIDTH   (KW),
        .WORD_W      (WW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Core model configuration (cycle offsets counted from first core_start cycle)
    int          cfg_rdy   = 2;
    int          cfg_done  = 5;
    bit          cfg_never = 1'b0;
    logic [31:0] cfg_ret   = 32'h0;

    // Locked core model
    bit active = 1'b0;
    int mcnt   = 0;
    initial begin
        bus.core_ready  = 1'b0;
        bus.core_done   = 1'b0;
        bus.core_idle   = 1'b1;
        bus.core_return = 32'h0;
        forever begin
            @(posedge ap_clk);
            #1;
            if (ap_rst) active = 1'b0;
            else if (!active && bus.core_start) begin
                active = 1'b1;
                mcnt   = 0;
            end else if (active) begin
                mcnt++;
                if (bus.rsp_valid) active = 1'b0;
            end
            bus.core_ready  = active && (mcnt == cfg_rdy);
            bus.core_done   = active && !cfg_never && (mcnt == cfg_done);
            bus.core_return = (active && mcnt == cfg_done) ? cfg_ret : 32'h0;
            bus.core_idle   = !active;
        end
    end

    // Scoreboard: push on request handshake, pop on response handshake
    logic [32:0] sb_q[$];
    logic [32:0] sb_exp;
    initial begin
        forever begin
            @(negedge ap_clk);
            if (!ap_rst) begin
                if (bus.req_valid && bus.req_ready)
                    sb_q.push_back(cfg_never ? {1'b1, 32'h0} : {1'b0, cfg_ret});
                if (bus.rsp_valid && bus.rsp_ready) begin
                    if (sb_q.size() == 0) chk("sb_unexpected_rsp", 64'd1, 64'd0);
                    else begin
                        sb_exp = sb_q.pop_front();
                        chk("sb_rsp_err",  {63'd0, bus.rsp_err}, {63'd0, sb_exp[32]});
                        chk("sb_rsp_data", {32'd0, bus.rsp_data}, {32'd0, sb_exp[31:0]});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge ap_clk);
        #2;
    endtask

    task automatic load_words(input int n, input int base);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            bus.key_valid = 1'b1;
            bus.key_data  = 32'(base + i);
            if (!bus.key_ready || bus.core_start || bus.req_ready) bad++;
            tick();
        end
        bus.key_valid = 1'b0;
        chk("load_gating", 64'(bad), 64'd0);
    endtask

    task automatic wait_rsp(input int limit, output int cyc);
        cyc = 0;
        while (!bus.rsp_valid && cyc < limit) begin
            tick();
            cyc++;
        end
        if (!bus.rsp_valid) chk("rsp_wait_bound", 64'd0, 64'd1);
    endtask

    task automatic consume();
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
    endtask

    int          cyc;
    int          starts;
    int          hold_bad;
    logic [31:0] tmp;

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_data   = 32'h0;
        bus.key_reload = 1'b0;
        bus.req_valid  = 1'b0;
        bus.rsp_ready  = 1'b0;
        ap_rst         = 1'b1;
        repeat (3) @(posedge ap_clk);
        #2;
        // Reset values
        chk("rst_core_start", {63'd0, bus.core_start}, 64'd0);
        chk("rst_rsp_valid",  {63'd0, bus.rsp_valid},  64'd0);
        chk("rst_rsp_data",   {32'd0, bus.rsp_data},   64'd0);
        chk("rst_rsp_err",    {63'd0, bus.rsp_err},    64'd0);
        chk("rst_key_loaded", {63'd0, bus.key_loaded}, 64'd0);
        chk("rst_core_key",   {63'd0, |bus.core_key},  64'd0);
        chk("rst_req_ready",  {63'd0, bus.req_ready},  64'd0);
        chk("rst_key_ready",  {63'd0, bus.key_ready},  64'd1);
        chk("rst_busy",       {63'd0, bus.busy},       64'd1);
        ap_rst = 1'b0;

        // Key load with a request pending throughout
        cfg_rdy = 2; cfg_done = 5; cfg_never = 1'b0; cfg_ret = 32'hDEADBEEF;
        bus.req_valid = 1'b1;
        load_words(383, 0);
        chk("loaded_early", {63'd0, bus.key_loaded}, 64'd0);
        load_words(1, 383);
        chk("loaded_after_last", {63'd0, bus.key_loaded}, 64'd1);
        chk("key_w0", {32'd0, bus.core_key[31:0]}, 64'd0);
        chk("key_w1", {32'd0, bus.core_key[63:32]}, 64'd1);
        tmp = 32'd383;
        chk("key_w383", {33'd0, bus.core_key[12286:12256]}, {33'd0, tmp[30:0]});
        chk("first_ready_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("ready_busy", {63'd0, bus.busy}, 64'd0);

        // Normal operation: ready at +2, done at +5
        tick();
        bus.req_valid = 1'b0;
        chk("start_after_req", {63'd0, bus.core_start}, 64'd1);
        starts = 0;
        cyc    = 0;
        while (!bus.rsp_valid && cyc < 40) begin
            if (bus.core_start) starts++;
            tick();
            cyc++;
        end
        chk("start_cycles", 64'(starts), 64'd3);
        chk("start_to_rsp", 64'(cyc), 64'd6);
        hold_bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (!bus.rsp_valid || bus.rsp_data !== 32'hDEADBEEF || bus.rsp_err) hold_bad++;
            tick();
        end
        chk("rsp_hold_stable", 64'(hold_bad), 64'd0);
        consume();
        chk("rsp_valid_drop", {63'd0, bus.rsp_valid}, 64'd0);
        chk("req_ready_after_rsp", {63'd0, bus.req_ready}, 64'd1);

        // Ready and done together in the first START cycle
        cfg_rdy = 0; cfg_done = 0; cfg_ret = 32'h12345678;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk("sim_start", {63'd0, bus.core_start}, 64'd1);
        tick();
        chk("sim_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
        chk("sim_rsp_data", {32'd0, bus.rsp_data}, 64'h12345678);
        chk("sim_start_drop", {63'd0, bus.core_start}, 64'd0);
        consume();

        // Watchdog timeout
        cfg_rdy = 0; cfg_done = 99; cfg_never = 1'b1; cfg_ret = 32'hFFFF0000;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        wait_rsp(40, cyc);
        chk("timeout_latency", 64'(cyc), 64'(TO + 1));
        chk("timeout_err", {63'd0, bus.rsp_err}, 64'd1);
        chk("timeout_data", {32'd0, bus.rsp_data}, 64'd0);
        consume();

        // Reload pulse during WAIT
        cfg_rdy = 2; cfg_done = 5; cfg_never = 1'b0; cfg_ret = 32'hA5A50001;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        tick(); tick(); tick();
        bus.key_reload = 1'b1;
        tick();
        bus.key_reload = 1'b0;
        wait_rsp(40, cyc);
        chk("reload_rsp_data", {32'd0, bus.rsp_data}, 64'hA5A50001);
        chk("reload_rsp_err", {63'd0, bus.rsp_err}, 64'd0);
        consume();
        chk("reload_in_load", {63'd0, bus.key_ready}, 64'd1);
        chk("reload_unloaded", {63'd0, bus.key_loaded}, 64'd0);
        chk("reload_key_clear", {63'd0, |bus.core_key}, 64'd0);

        // Reset in the middle of a load
        load_words(100, 1000);
        #1;
        ap_rst = 1'b1;
        #1;
        chk("rst_mid_key", {63'd0, |bus.core_key}, 64'd0);
        chk("rst_mid_key_ready", {63'd0, bus.key_ready}, 64'd1);
        tick();
        ap_rst = 1'b0;
        load_words(383, 32'h5000);
        chk("reload_full_needed", {63'd0, bus.key_loaded}, 64'd0);
        load_words(1, 32'h5000 + 383);
        chk("reload_loaded", {63'd0, bus.key_loaded}, 64'd1);
        chk("reload_w0", {32'd0, bus.core_key[31:0]}, 64'h5000);
        chk("reload_w100", {32'd0, bus.core_key[3231:3200]}, 64'h5064);
        tmp = 32'h5000 + 32'd383;
        chk("reload_w383", {33'd0, bus.core_key[12286:12256]}, {33'd0, tmp[30:0]});

        // One more operation after the reload
        cfg_rdy = 1; cfg_done = 3; cfg_ret = 32'h0BADF00D;
        bus.req_valid = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        wait_rsp(40, cyc);
        chk("final_rsp_data", {32'd0, bus.rsp_data}, 64'h0BADF00D);
        consume();
        tick();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
